ifetch_queue: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter register: it takes the current fetch address, issues in-order requests to instruction memory over a request/grant, response-valid handshake, and pairs each returned word with its PC in a small in-order queue. It presents instructions to decode with valid/ready and supports a flush on redirect (branch/jump), discarding any responses still in flight. It also tells the next-PC logic when the current PC has been consumed.

---
 rtl/ifetch_queue.sv | 118 +++++++++++
 tb/tb_ifetch_queue.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order imem requests for pc_i and pairs each
// response with its PC for decode. Optional same-cycle bypass via `IFQ_BYPASS_EN.
module ifetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        pc_taken_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        flush_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        filled;
  } entry_t;

  entry_t        entry_q [DEPTH];
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] read_q, read_d;
  logic [PW-1:0] disc_q, disc_d;

  logic [PW-1:0] occupancy;
  logic [PW-1:0] outstanding;
  logic          credit;
  logic          grant;
  logic          rsp_drop;
  logic          rsp_fill;
  logic          byp_hit;
  logic          pop;
  logic          byp_consume;
  entry_t        head;

  assign occupancy   = alloc_q - read_q;
  assign outstanding = alloc_q - fill_q;
  // Discarded in-flight responses still occupy memory-side slots, so they consume credit.
  assign credit      = ({1'b0, occupancy} + {1'b0, disc_q}) < DEPTH_W;

  // A response with nothing outstanding and nothing to discard is a protocol error; ignore it.
  assign rsp_drop = imem_rvalid_i && (disc_q != '0);
  assign rsp_fill = imem_rvalid_i && (disc_q == '0) && (outstanding != '0);

  assign imem_req_o  = !rst_i && !flush_i && credit;
  assign imem_addr_o = {pc_i[31:2], 2'b00};
  assign grant       = imem_req_o && imem_gnt_i;
  assign pc_taken_o  = grant;

  assign head = entry_q[read_q[AW-1:0]];

`ifdef IFQ_BYPASS_EN
  assign byp_hit    = rsp_fill && (fill_q == read_q);
  assign instr_o    = byp_hit ? imem_rdata_i : head.data;
`else
  assign byp_hit    = 1'b0;
  assign instr_o    = head.data;
`endif
  assign instr_pc_o = head.pc;

  assign instr_valid_o = !rst_i && !flush_i &&
                         (((fill_q != read_q) && head.filled) || byp_hit);
  assign pop           = instr_valid_o && instr_ready_i;
  assign byp_consume   = byp_hit && pop;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    alloc_d = alloc_q + PW'(grant);
    fill_d  = fill_q + PW'(rsp_fill);
    read_d  = read_q + PW'(pop);
    disc_d  = disc_q - PW'(rsp_drop);
    if (flush_i) begin
      alloc_d = '0;
      fill_d  = '0;
      read_d  = '0;
      disc_d  = (outstanding - PW'(rsp_fill)) + (disc_q - PW'(rsp_drop));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q <= '0;
      fill_q  <= '0;
      read_q  <= '0;
      disc_q  <= '0;
      // NOTE: the queue array is small and instr_o/instr_pc_o must read 0 out of reset, so it is reset too.
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      read_q  <= read_d;
      disc_q  <= disc_d;
      if (grant) begin
        entry_q[alloc_q[AW-1:0]].pc     <= pc_i;
        entry_q[alloc_q[AW-1:0]].filled <= 1'b0;
      end
      if (rsp_fill && !byp_consume && !flush_i) begin
        entry_q[fill_q[AW-1:0]].data   <= imem_rdata_i;
        entry_q[fill_q[AW-1:0]].filled <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue (DEPTH = 4); expected values are hand-derived.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pc_taken_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int errors = 0;
  int checks = 0;

  ifetch_queue #(.DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .pc_taken_o    (pc_taken_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .flush_i       (flush_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    flush_i       = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; pc_i = 32'h40; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hFFFF_FFFF; flush_i = 1'b0; instr_ready_i = 1'b1;
    step();
    step();
    checks++;
    if ({imem_req_o, pc_taken_o, instr_valid_o} !== 3'b000) begin
      $display("FAIL reset_outputs: req/taken/valid=%b expected 000", {imem_req_o, pc_taken_o, instr_valid_o});
      errors++;
    end
    rst_i = 1'b0;
    idle();
    #1;
    checks++;
    if ({instr_o, instr_pc_o} !== 64'h0) begin
      $display("FAIL reset_data: instr=%h pc=%h expected 0/0", instr_o, instr_pc_o);
      errors++;
    end
    checks++;
    if (instr_valid_o !== 1'b0) begin
      $display("FAIL reset_no_fill: valid=%b expected 0", instr_valid_o);
      errors++;
    end
    checks++;
    if ({imem_req_o, pc_taken_o} !== 2'b10) begin
      $display("FAIL reset_first_req: req/taken=%b expected 10", {imem_req_o, pc_taken_o});
      errors++;
    end
    step();
  endtask

  task automatic test_streaming();
    for (int c = 0; c < 7; c++) begin
      int  k;
      logic exp_v;
      pc_i          = 32'(4 * c);
      imem_gnt_i    = (c < 4);
      imem_rvalid_i = (c >= 1) && (c <= 4);
      imem_rdata_i  = 32'(32'hA0 + c - 1);
      instr_ready_i = 1'b1;
      #1;
      checks++;
      if (pc_taken_o !== (c < 4)) begin
        $display("FAIL stream_taken c=%0d: got %b expected %b", c, pc_taken_o, (c < 4));
        errors++;
      end
      k = c - LAT;
      exp_v = (k >= 0) && (k < 4);
      checks++;
      if (instr_valid_o !== exp_v ||
          (exp_v && (instr_o !== 32'(32'hA0 + k) || instr_pc_o !== 32'(4 * k)))) begin
        $display("FAIL stream_out c=%0d: valid=%b instr=%h pc=%h expected valid=%b instr=%h pc=%h",
                 c, instr_valid_o, instr_o, instr_pc_o, exp_v, 32'(32'hA0 + k), 32'(4 * k));
        errors++;
      end
      step();
    end
    idle();
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      pc_i          = 32'(32'h200 + 4 * c);
      imem_gnt_i    = 1'b1;
      imem_rvalid_i = (c >= 1);
      imem_rdata_i  = 32'(32'hB0 + c - 1);
      instr_ready_i = 1'b0;
      #1;
      checks++;
      if ({imem_req_o, pc_taken_o} !== {2{c < 4}}) begin
        $display("FAIL bp_grant c=%0d: req/taken=%b expected %b", c, {imem_req_o, pc_taken_o}, {2{c < 4}});
        errors++;
      end
      step();
    end
    imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
    #1;
    checks++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_o !== 32'hB0 || instr_pc_o !== 32'h200) begin
      $display("FAIL bp_pop: req=%b valid=%b instr=%h pc=%h expected 0/1/b0/200",
               imem_req_o, instr_valid_o, instr_o, instr_pc_o);
      errors++;
    end
    step();
    imem_gnt_i = 1'b0; instr_ready_i = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b1) begin
      $display("FAIL bp_req_after_pop: req=%b expected 1", imem_req_o);
      errors++;
    end
    step();
    for (int k = 1; k < 4; k++) begin
      instr_ready_i = 1'b1;
      #1;
      checks++;
      if (instr_valid_o !== 1'b1 || instr_o !== 32'(32'hB0 + k) || instr_pc_o !== 32'(32'h200 + 4 * k)) begin
        $display("FAIL bp_drain k=%0d: valid=%b instr=%h pc=%h", k, instr_valid_o, instr_o, instr_pc_o);
        errors++;
      end
      step();
    end
    idle();
    #1;
    checks++;
    if (instr_valid_o !== 1'b0) begin
      $display("FAIL bp_empty: valid=%b expected 0", instr_valid_o);
      errors++;
    end
    step();
  endtask

  task automatic test_flush();
    pc_i = 32'h10; imem_gnt_i = 1'b1;
    step();
    pc_i = 32'h14; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h11;
    step();
    pc_i = 32'h18; imem_rvalid_i = 1'b0;
    step();
    pc_i = 32'h1C; flush_i = 1'b1;
    #1;
    checks++;
    if ({imem_req_o, pc_taken_o, instr_valid_o} !== 3'b000) begin
      $display("FAIL flush_cycle: req/taken/valid=%b expected 000", {imem_req_o, pc_taken_o, instr_valid_o});
      errors++;
    end
    step();
    flush_i = 1'b0; pc_i = 32'h100; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD;
    #1;
    checks++;
    if ({imem_req_o, pc_taken_o, instr_valid_o} !== 3'b110) begin
      $display("FAIL flush_regrant: req/taken/valid=%b expected 110", {imem_req_o, pc_taken_o, instr_valid_o});
      errors++;
    end
    step();
    imem_gnt_i = 1'b0; imem_rdata_i = 32'hBEEF;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0) begin
      $display("FAIL flush_drop: valid=%b instr=%h expected valid 0", instr_valid_o, instr_o);
      errors++;
    end
    step();
    imem_rdata_i = 32'h55;
    step();
    imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
    #1;
    checks++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h55 || instr_pc_o !== 32'h100) begin
      $display("FAIL flush_new: valid=%b instr=%h pc=%h expected 1/55/100", instr_valid_o, instr_o, instr_pc_o);
      errors++;
    end
    step();
    idle();
    #1;
    checks++;
    if (instr_valid_o !== 1'b0) begin
      $display("FAIL flush_empty: valid=%b expected 0", instr_valid_o);
      errors++;
    end
    step();
  endtask

  task automatic test_flush_rvalid();
    imem_gnt_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      pc_i = 32'(32'h20 + 4 * c);
      step();
    end
    imem_gnt_i = 1'b0; flush_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h77;
    step();
    flush_i = 1'b0; imem_rdata_i = 32'hD1;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
      $display("FAIL fr_drop1: valid=%b req=%b expected 0/1", instr_valid_o, imem_req_o);
      errors++;
    end
    step();
    imem_rdata_i = 32'hD2;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0) begin
      $display("FAIL fr_drop2: valid=%b instr=%h expected valid 0", instr_valid_o, instr_o);
      errors++;
    end
    step();
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; pc_i = 32'h300;
    #1;
    checks++;
    if (instr_valid_o !== 1'b0 || pc_taken_o !== 1'b1) begin
      $display("FAIL fr_after: valid=%b taken=%b expected 0/1", instr_valid_o, pc_taken_o);
      errors++;
    end
    step();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h33;
    step();
    imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
    #1;
    checks++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h33 || instr_pc_o !== 32'h300) begin
      $display("FAIL fr_kept: valid=%b instr=%h pc=%h expected 1/33/300", instr_valid_o, instr_o, instr_pc_o);
      errors++;
    end
    step();
    idle();
  endtask

  task automatic test_misaligned();
    pc_i = 32'h103; imem_gnt_i = 1'b1;
    #1;
    checks++;
    if (imem_addr_o !== 32'h100 || pc_taken_o !== 1'b1) begin
      $display("FAIL mis_addr: addr=%h taken=%b expected 100/1", imem_addr_o, pc_taken_o);
      errors++;
    end
    step();
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h99;
    step();
    imem_rvalid_i = 1'b0; instr_ready_i = 1'b1;
    #1;
    checks++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h99 || instr_pc_o !== 32'h103) begin
      $display("FAIL mis_pc: valid=%b instr=%h pc=%h expected 1/99/103", instr_valid_o, instr_o, instr_pc_o);
      errors++;
    end
    step();
    idle();
    #1;
    checks++;
    if (instr_valid_o !== 1'b0) begin
      $display("FAIL mis_empty: valid=%b expected 0", instr_valid_o);
      errors++;
    end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_rvalid();
    test_misaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
